// File: rtl/aes_param_fifo_if.sv
// Handshake/data bundle between an AES datapath stage and the staging FIFO.
interface aes_param_fifo_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
);
    logic              flush;
    logic              wr_en;
    logic [DATA_W-1:0] din;
    logic              rd_en;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              empty;
    logic              full;
    logic              almost_full;
    logic              almost_empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;

    // Producer/consumer side driving the FIFO
    modport master (
        output flush, wr_en, din, rd_en,
        input  dout, dout_valid, empty, full, almost_full, almost_empty,
               count, overflow, underflow
    );

    // The FIFO itself
    modport slave (
        input  flush, wr_en, din, rd_en,
        output dout, dout_valid, empty, full, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/aes_param_fifo.sv
// Parametrised synchronous FIFO for AES256 stage buffering.
// Occupancy is tracked by an explicit counter; full/empty come from it,
// so pointers can wrap freely. FWFT selects a combinational head display.
module aes_param_fifo #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 2,
    parameter int AF_THRESH = 3,
    parameter int AE_THRESH = 1,
    parameter int FWFT      = 0
) (
    input  logic            clk,
    input  logic            rst,
    aes_param_fifo_if.slave bus
);
    localparam int              DEPTH   = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] C_AF    = (ADDR_W+1)'(AF_THRESH);
    localparam logic [ADDR_W:0] C_AE    = (ADDR_W+1)'(AE_THRESH);
    localparam bit              C_FWFT  = (FWFT != 0);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic [DATA_W-1:0] r_dout;
    logic              r_dout_valid;
    logic              r_overflow;
    logic              r_underflow;

    logic w_empty;
    logic w_full;
    logic w_rd_acc;
    logic w_wr_acc;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == C_DEPTH);
    // Flush swallows both requests, so neither is accepted nor flagged.
    assign w_rd_acc = bus.rd_en & ~w_empty & ~bus.flush;
    // A write into a full FIFO is fine when a read frees the slot this cycle.
    assign w_wr_acc = bus.wr_en & (~w_full | w_rd_acc) & ~bus.flush;

    // Storage array; contents survive reset and flush by design.
    always_ff @(posedge clk) begin
        if (w_wr_acc)
            r_mem[r_wr_ptr] <= bus.din;
    end

    // Pointers, occupancy, registered read port and sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
        end else if (bus.flush) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_dout_valid <= 1'b0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            if (w_wr_acc)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_dout   <= r_mem[r_rd_ptr];
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_dout_valid <= w_rd_acc;
            if (bus.wr_en && !w_wr_acc)
                r_overflow <= 1'b1;
            if (bus.rd_en && !w_rd_acc)
                r_underflow <= 1'b1;
        end
    end

    assign bus.dout         = C_FWFT ? r_mem[r_rd_ptr] : r_dout;
    assign bus.dout_valid   = C_FWFT ? ~w_empty : r_dout_valid;
    assign bus.empty        = w_empty;
    assign bus.full         = w_full;
    assign bus.almost_full  = (r_count >= C_AF);
    assign bus.almost_empty = (r_count <= C_AE);
    assign bus.count        = r_count;
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;
endmodule

// File: tb/tb_aes_param_fifo.sv
// Bench for aes_param_fifo: a standard-mode 8x4 instance and an FWFT 32x8
// instance, both compared every cycle against queue-based reference models.
module tb_aes_param_fifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    aes_param_fifo_if #(.DATA_W(8),  .ADDR_W(2)) if0 ();
    aes_param_fifo_if #(.DATA_W(32), .ADDR_W(3)) if1 ();

    aes_param_fifo u_std (.clk(clk), .rst(rst), .bus(if0));

    aes_param_fifo #(
        .DATA_W(32), .ADDR_W(3), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1)
    ) u_fwft (.clk(clk), .rst(rst), .bus(if1));

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    logic [7:0]  q0 [$];
    logic [31:0] q1 [$];
    logic        ovf0 = 0, udf0 = 0, dv0 = 0;
    logic [7:0]  dout0 = 0;
    logic        ovf1 = 0, udf1 = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        int s0 = q0.size();
        int s1 = q1.size();
        chk("std.count", 64'(if0.count), 64'(s0));
        chk("std.empty", 64'(if0.empty), 64'(s0 == 0));
        chk("std.full",  64'(if0.full),  64'(s0 == 4));
        chk("std.af",    64'(if0.almost_full),  64'(s0 >= 3));
        chk("std.ae",    64'(if0.almost_empty), 64'(s0 <= 1));
        chk("std.ovf",   64'(if0.overflow),  64'(ovf0));
        chk("std.udf",   64'(if0.underflow), 64'(udf0));
        chk("std.dv",    64'(if0.dout_valid), 64'(dv0));
        chk("std.dout",  64'(if0.dout), 64'(dout0));
        chk("fw.count",  64'(if1.count), 64'(s1));
        chk("fw.empty",  64'(if1.empty), 64'(s1 == 0));
        chk("fw.full",   64'(if1.full),  64'(s1 == 8));
        chk("fw.af",     64'(if1.almost_full),  64'(s1 >= 6));
        chk("fw.ae",     64'(if1.almost_empty), 64'(s1 <= 2));
        chk("fw.ovf",    64'(if1.overflow),  64'(ovf1));
        chk("fw.udf",    64'(if1.underflow), 64'(udf1));
        chk("fw.dv",     64'(if1.dout_valid), 64'(s1 != 0));
        if (s1 != 0)
            chk("fw.dout", 64'(if1.dout), 64'(q1[0]));
    endtask

    // One clock cycle: drive both FIFOs, advance the models, check.
    task automatic step(input logic w0, input logic [7:0] d0, input logic r0, input logic f0,
                        input logic w1, input logic [31:0] d1, input logic r1, input logic f1);
        bit ra, wa;
        if0.wr_en = w0; if0.din = d0; if0.rd_en = r0; if0.flush = f0;
        if1.wr_en = w1; if1.din = d1; if1.rd_en = r1; if1.flush = f1;
        @(posedge clk);
        // standard-mode model
        if (f0) begin
            q0.delete(); ovf0 = 0; udf0 = 0; dv0 = 0;
        end else begin
            ra = r0 && q0.size() > 0;
            wa = w0 && (q0.size() < 4 || ra);
            dv0 = ra;
            if (ra) dout0 = q0.pop_front();
            if (wa) q0.push_back(d0);
            if (w0 && !wa) ovf0 = 1;
            if (r0 && !ra) udf0 = 1;
        end
        // FWFT model
        if (f1) begin
            q1.delete(); ovf1 = 0; udf1 = 0;
        end else begin
            ra = r1 && q1.size() > 0;
            wa = w1 && (q1.size() < 8 || ra);
            if (ra) void'(q1.pop_front());
            if (wa) q1.push_back(d1);
            if (w1 && !wa) ovf1 = 1;
            if (r1 && !ra) udf1 = 1;
        end
        #1;
        check_all();
    endtask

    task automatic s0(input logic w, input logic [7:0] d, input logic r, input logic f);
        step(w, d, r, f, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        if0.wr_en = 0; if0.din = 0; if0.rd_en = 0; if0.flush = 0;
        if1.wr_en = 0; if1.din = 0; if1.rd_en = 0; if1.flush = 0;
        repeat (2) @(posedge clk);
        #1;
        check_all();                      // reset state
        @(negedge clk);
        rst = 1'b0;

        // fill to full, then one rejected write
        s0(1, 8'h11, 0, 0);
        s0(1, 8'h22, 0, 0);
        s0(1, 8'h33, 0, 0);
        s0(1, 8'h44, 0, 0);
        s0(1, 8'h55, 0, 0);
        // write+read while full, then drain
        s0(1, 8'h55, 1, 0);
        chk("std.first_out", 64'(if0.dout), 64'h11);
        for (int i = 0; i < 4; i++) s0(0, 8'h0, 1, 0);
        chk("std.last_out", 64'(if0.dout), 64'h55);
        // underflow on empty read, then flush clears flags
        s0(0, 8'h0, 1, 0);
        s0(0, 8'h0, 0, 1);
        // wrap-around with alternating write/read
        for (int i = 0; i < 10; i++) begin
            s0(1, 8'(i), 0, 0);
            s0(0, 8'h0, 1, 0);
            chk("std.wrap", 64'(if0.dout), 64'(i));
        end

        // FWFT: word visible the cycle after its write, then pop
        step(0, 8'h0, 0, 0, 1, 32'hDEADBEEF, 0, 0);
        chk("fw.show", 64'(if1.dout), 64'hDEADBEEF);
        step(0, 8'h0, 0, 0, 0, 32'h0, 1, 0);

        // async reset mid-transfer
        for (int i = 0; i < 3; i++) step(1, 8'hA0 + 8'(i), 0, 0, 1, 32'hC0DE0000 + 32'(i), 0, 0);
        if0.wr_en = 0; if1.wr_en = 0;
        #2 rst = 1'b1;
        #1;
        q0.delete(); q1.delete();
        ovf0 = 0; udf0 = 0; dv0 = 0; dout0 = 0; ovf1 = 0; udf1 = 0;
        check_all();
        #1 rst = 1'b0;
        // flush concurrent with write is ignored
        step(1, 8'h77, 0, 1, 1, 32'h77, 0, 1);
        step(0, 8'h0, 0, 0, 0, 32'h0, 0, 0);

        // randomized traffic, biased toward filling then draining
        for (int i = 0; i < 600; i++) begin
            int wp = ((i / 50) % 2 == 0) ? 75 : 30;
            step(($urandom % 100) < wp, 8'($urandom), ($urandom % 100) < (100 - wp),
                 ($urandom % 40) == 0,
                 ($urandom % 100) < wp, $urandom, ($urandom % 100) < (100 - wp),
                 ($urandom % 40) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
